// File: rtl/sbox_seq_ctrl_pkg.sv
// aes_dom_pkg: shared constants and FSM state type for the DOM-masked AES
// S-box sequencer.
//   BYTE_W    - width of one AES byte
//   NUM_BYTES - bytes per 128-bit AES state share
//   CNT_W     - width of the issue/capture counters (saturate at NUM_BYTES)
package aes_dom_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqStateT;

endpackage

// File: rtl/sbox_seq_ctrl_if.sv
// sbox_seq_ctrl_if: bundles the three handshakes around the S-box sequencer.
//   Start side : StartValidxSI / StartReadyxSO / StatexDI (128 bits per share)
//   S-box side : RandValidxSI, SboxEnxSO, SboxInxDO, SboxOutxDI (8 bits per share)
//   Result side: OutValidxSO / OutReadyxSI / StatexDO (128 bits per share)
// Modports:
//   master - environment (producer, consumer, S-box and randomness source)
//   slave  - the sequencer itself
interface sbox_seq_ctrl_if #(
    parameter int unsigned SHARES = 2
);

    logic                    StartValidxSI;
    logic                    StartReadyxSO;
    logic [128*SHARES-1:0]   StatexDI;
    logic                    RandValidxSI;
    logic                    SboxEnxSO;
    logic [8*SHARES-1:0]     SboxInxDO;
    logic [8*SHARES-1:0]     SboxOutxDI;
    logic                    OutValidxSO;
    logic                    OutReadyxSI;
    logic [128*SHARES-1:0]   StatexDO;

    modport master (
        output StartValidxSI,
        input  StartReadyxSO,
        output StatexDI,
        output RandValidxSI,
        input  SboxEnxSO,
        input  SboxInxDO,
        output SboxOutxDI,
        input  OutValidxSO,
        output OutReadyxSI,
        input  StatexDO
    );

    modport slave (
        input  StartValidxSI,
        output StartReadyxSO,
        input  StatexDI,
        input  RandValidxSI,
        output SboxEnxSO,
        output SboxInxDO,
        input  SboxOutxDI,
        output OutValidxSO,
        input  OutReadyxSI,
        output StatexDO
    );

endinterface

// File: rtl/sbox_seq_ctrl_valid_pipe.sv
// sbox_valid_pipe: LATENCY-deep valid shift register that mirrors the S-box
// pipeline. It only advances when the S-box advances, so the tail marks the
// enabled cycle in which an issued byte appears on the S-box output.
// Ports:
//   ClkxCI   - clock, rising edge
//   RstxBI   - asynchronous active-low reset
//   EnxSI    - pipeline advance enable
//   ValidxSI - valid bit entering the pipe
//   TailxSO  - valid bit leaving the pipe
module sbox_valid_pipe #(
    parameter int unsigned LATENCY = 4
) (
    input  logic ClkxCI,
    input  logic RstxBI,
    input  logic EnxSI,
    input  logic ValidxSI,
    output logic TailxSO
);

    logic [LATENCY-1:0] pipeQ;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            pipeQ <= '0;
        end else if (EnxSI) begin
            pipeQ[0] <= ValidxSI;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                pipeQ[k] <= pipeQ[k-1];
            end
        end
    end

    assign TailxSO = pipeQ[LATENCY-1];

endmodule

// File: rtl/sbox_seq_ctrl.sv
// sbox_seq_ctrl: sequencer for one shared, pipelined DOM-masked AES S-box.
// Takes a full shared AES state, issues its 16 bytes (all shares of byte i
// together) into the S-box one per enabled cycle, collects results LATENCY
// enabled cycles later and returns the SubBytes-transformed shared state.
// The S-box only advances when fresh randomness is available.
// Ports:
//   ClkxCI - clock, rising edge
//   RstxBI - asynchronous active-low reset
//   bus    - sbox_seq_ctrl_if.slave (start / S-box / result handshakes)
// Parameters:
//   SHARES  - number of masking shares (>=2)
//   LATENCY - S-box pipeline depth in enabled cycles (>=1)
// Build option:
//   SBOX_SEQ_ZEROIZE_EN - clear the input buffer when the block completes,
//   clear the output buffer on the result handshake, and drive SboxInxDO to
//   zero in every non-issuing cycle. Undefined: buffers keep stale contents
//   and SboxInxDO holds its last value while the S-box is stalled.
module sbox_seq_ctrl
    import aes_dom_pkg::*;
#(
    parameter int unsigned SHARES  = 2,
    parameter int unsigned LATENCY = 4
) (
    input  logic           ClkxCI,
    input  logic           RstxBI,
    sbox_seq_ctrl_if.slave bus
);

    localparam int unsigned     IDX_W    = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

    typedef logic [SHARES-1:0][BYTE_W-1:0]                shByteT;
    typedef logic [SHARES-1:0][NUM_BYTES-1:0][BYTE_W-1:0] shStateT;

    seqStateT         stateQ;
    shStateT          inBufQ;
    shStateT          outBufQ;
    logic [CNT_W-1:0] issueCntQ;
    logic [CNT_W-1:0] capCntQ;
    logic             startReadyQ;
    logic             outValidQ;

    logic   sboxEn;
    logic   canIssue;
    logic   tailValid;
    logic   capture;
    shByteT issueByte;
    shByteT sboxOutSh;
    shByteT sboxIn;

    // Each share keeps its own datapath; all shares are selected by the
    // same byte index and never mixed.
    always_comb begin
        sboxEn    = (stateQ == RUN) && bus.RandValidxSI;
        canIssue  = issueCntQ < CNT_FULL;
        capture   = sboxEn && tailValid && (capCntQ < CNT_FULL);
        sboxOutSh = bus.SboxOutxDI;
        issueByte = '0;
        for (int unsigned s = 0; s < SHARES; s++) begin
            issueByte[s] = inBufQ[s][issueCntQ[IDX_W-1:0]];
        end
    end

    sbox_valid_pipe #(
        .LATENCY(LATENCY)
    ) u_validPipe (
        .ClkxCI  (ClkxCI),
        .RstxBI  (RstxBI),
        .EnxSI   (sboxEn),
        .ValidxSI(canIssue),
        .TailxSO (tailValid)
    );

`ifdef SBOX_SEQ_ZEROIZE_EN
    always_comb begin
        sboxIn = '0;
        if (sboxEn && canIssue) begin
            sboxIn = issueByte;
        end
    end
`else
    // Last value seen by the S-box; replayed while it is stalled so the
    // S-box input does not toggle without an enable.
    shByteT sboxInQ;

    always_comb begin
        sboxIn = sboxInQ;
        if (sboxEn) begin
            sboxIn = canIssue ? issueByte : '0;
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            sboxInQ <= '0;
        end else begin
            sboxInQ <= sboxIn;
        end
    end
`endif

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            stateQ      <= IDLE;
            inBufQ      <= '0;
            outBufQ     <= '0;
            issueCntQ   <= '0;
            capCntQ     <= '0;
            startReadyQ <= 1'b1;
            outValidQ   <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (bus.StartValidxSI) begin
                        inBufQ      <= bus.StatexDI;
                        issueCntQ   <= '0;
                        capCntQ     <= '0;
                        startReadyQ <= 1'b0;
                        stateQ      <= RUN;
                    end
                end
                RUN: begin
                    if (sboxEn && canIssue) begin
                        issueCntQ <= issueCntQ + 1'b1;
                    end
                    if (capture) begin
                        for (int unsigned s = 0; s < SHARES; s++) begin
                            outBufQ[s][capCntQ[IDX_W-1:0]] <= sboxOutSh[s];
                        end
                        capCntQ <= capCntQ + 1'b1;
                        if (capCntQ == CNT_LAST) begin
                            outValidQ <= 1'b1;
                            stateQ    <= DONE;
`ifdef SBOX_SEQ_ZEROIZE_EN
                            inBufQ    <= '0;
`endif
                        end
                    end
                end
                DONE: begin
                    // StartValidxSI is not looked at here, so consecutive
                    // blocks are always separated by at least one IDLE cycle.
                    if (bus.OutReadyxSI) begin
                        outValidQ   <= 1'b0;
                        startReadyQ <= 1'b1;
                        stateQ      <= IDLE;
`ifdef SBOX_SEQ_ZEROIZE_EN
                        outBufQ     <= '0;
`endif
                    end
                end
                default: begin
                    stateQ      <= IDLE;
                    startReadyQ <= 1'b1;
                    outValidQ   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.StartReadyxSO = startReadyQ;
    assign bus.OutValidxSO   = outValidQ;
    assign bus.SboxEnxSO     = sboxEn;
    assign bus.SboxInxDO     = sboxIn;
    assign bus.StatexDO      = outBufQ;

endmodule
